// File: rtl/riscv_sp_pkg.sv
// Shared types for the register status table: the per-register entry
// {pending, tag} and the default table geometry.
package riscv_sp_pkg;

    localparam int TAG_W_DEF    = 6;
    localparam int NUM_REGS_DEF = 32;

    typedef struct packed {
        logic                 pending;
        logic [TAG_W_DEF-1:0] tag;
    } rst_entry_t;

    localparam rst_entry_t ENTRY_ZERO = '{pending: 1'b0, tag: '0};

endpackage

// File: rtl/rst_cdb_clear.sv
// CDB wake-up for one copy of the register status table.
// Ports: entries_in (stored vector), cdb_valid/cdb_tag (broadcast buses),
//        entries_out (vector with every matching pending entry zeroed).
module rst_cdb_clear
    import riscv_sp_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_CDB  = 2
) (
    input  rst_entry_t [NUM_REGS-1:0]          entries_in,
    input  logic       [NUM_CDB-1:0]           cdb_valid,
    input  logic       [NUM_CDB*TAG_W_DEF-1:0] cdb_tag,
    output rst_entry_t [NUM_REGS-1:0]          entries_out
);

    // Each bus is compared against the stored entry, so several buses can
    // retire several different registers in the same cycle.
    always_comb begin
        entries_out = entries_in;
        for (int r = 0; r < NUM_REGS; r++) begin
            for (int c = 0; c < NUM_CDB; c++) begin
                if (entries_in[r].pending && cdb_valid[c] &&
                    entries_in[r].tag == cdb_tag[c*TAG_W_DEF +: TAG_W_DEF]) begin
                    entries_out[r] = ENTRY_ZERO;
                end
            end
        end
    end

endmodule

// File: rtl/rst_mp_ckpt.sv
// Multi-port register status table with branch checkpoints.
// Ports: clk, rst (async high), flush; disp_valid/addr/tag (rename lanes);
//        rd_addr -> rd_tag/rd_pending (source lookups with CDB bypass);
//        cdb_valid/tag; ckpt_take/ckpt_id; ckpt_restore/restore_id;
//        pending_cnt (registered number of pending registers).
module rst_mp_ckpt
    import riscv_sp_pkg::*;
#(
    parameter  int NUM_REGS = NUM_REGS_DEF,
    parameter  int TAG_W    = TAG_W_DEF,
    parameter  int NUM_DISP = 2,
    parameter  int NUM_CDB  = 2,
    parameter  int NUM_RD   = 4,
    parameter  int NUM_CKPT = 4,
    localparam int AW       = $clog2(NUM_REGS),
    localparam int CW       = $clog2(NUM_CKPT),
    localparam int CNT_W    = $clog2(NUM_REGS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_DISP-1:0]       disp_valid,
    input  logic [NUM_DISP*AW-1:0]    disp_addr,
    input  logic [NUM_DISP*TAG_W-1:0] disp_tag,
    input  logic [NUM_RD*AW-1:0]      rd_addr,
    output logic [NUM_RD*TAG_W-1:0]   rd_tag,
    output logic [NUM_RD-1:0]         rd_pending,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    input  logic                      ckpt_take,
    input  logic [CW-1:0]             ckpt_id,
    input  logic                      ckpt_restore,
    input  logic [CW-1:0]             restore_id,
    output logic [CNT_W-1:0]          pending_cnt
);

    rst_entry_t [NUM_REGS-1:0] tbl_q;
    rst_entry_t [NUM_REGS-1:0] tbl_clr;
    rst_entry_t [NUM_REGS-1:0] tbl_nxt;
    rst_entry_t [NUM_REGS-1:0] tbl_d;
    rst_entry_t [NUM_REGS-1:0] ckpt_q   [NUM_CKPT];
    rst_entry_t [NUM_REGS-1:0] ckpt_clr [NUM_CKPT];
    rst_entry_t [NUM_REGS-1:0] ckpt_d   [NUM_CKPT];
    logic       [CNT_W-1:0]    cnt_d;

    // Wake-up of the live table; its output also feeds the read bypass.
    rst_cdb_clear #(
        .NUM_REGS (NUM_REGS),
        .NUM_CDB  (NUM_CDB)
    ) u_live_clr (
        .entries_in  (tbl_q),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .entries_out (tbl_clr)
    );

    // Checkpoints keep listening to the CDB so a restore never brings back
    // a tag that has already completed.
    for (genvar k = 0; k < NUM_CKPT; k++) begin : g_ckpt_clr
        rst_cdb_clear #(
            .NUM_REGS (NUM_REGS),
            .NUM_CDB  (NUM_CDB)
        ) u_ckpt_clr (
            .entries_in  (ckpt_q[k]),
            .cdb_valid   (cdb_valid),
            .cdb_tag     (cdb_tag),
            .entries_out (ckpt_clr[k])
        );
    end

    // Normal update: CDB clears first, then lanes oldest to youngest so the
    // youngest writer of a register wins and dispatch beats a same-cycle clear.
    always_comb begin : disp_upd
        logic [AW-1:0] da;
        da      = '0;
        tbl_nxt = tbl_clr;
        for (int l = 0; l < NUM_DISP; l++) begin
            da = disp_addr[l*AW +: AW];
            if (disp_valid[l] && da != '0) begin
                tbl_nxt[da].pending = 1'b1;
                tbl_nxt[da].tag     = disp_tag[l*TAG_W +: TAG_W];
            end
        end
    end

    // Mispredict recovery replaces the whole table and suppresses dispatch.
    always_comb begin
        tbl_d    = ckpt_restore ? ckpt_clr[restore_id] : tbl_nxt;
        tbl_d[0] = ENTRY_ZERO;
    end

    // A snapshot captures the post-dispatch state; a restore in the same
    // cycle cancels any take so the restored slot stays intact.
    always_comb begin
        for (int k = 0; k < NUM_CKPT; k++) begin
            if (ckpt_take && !ckpt_restore && ckpt_id == CW'(k)) begin
                ckpt_d[k] = tbl_nxt;
            end else begin
                ckpt_d[k] = ckpt_clr[k];
            end
        end
    end

    // Counting the next state lets pending_cnt match the table one edge later.
    always_comb begin
        cnt_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d = cnt_d + CNT_W'(tbl_d[r].pending);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl_q       <= '0;
            pending_cnt <= '0;
            for (int k = 0; k < NUM_CKPT; k++) begin
                ckpt_q[k] <= '0;
            end
        end else if (flush) begin
            tbl_q       <= '0;
            pending_cnt <= '0;
            for (int k = 0; k < NUM_CKPT; k++) begin
                ckpt_q[k] <= '0;
            end
        end else begin
            tbl_q       <= tbl_d;
            pending_cnt <= cnt_d;
            for (int k = 0; k < NUM_CKPT; k++) begin
                ckpt_q[k] <= ckpt_d[k];
            end
        end
    end

    // Reads come from the cleared view, so a tag on the CDB this cycle
    // already reads as not pending with a zero tag.
    always_comb begin : rd_mux
        logic [AW-1:0] ra;
        rst_entry_t    e;
        ra         = '0;
        e          = ENTRY_ZERO;
        rd_tag     = '0;
        rd_pending = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            ra = rd_addr[p*AW +: AW];
            e  = (ra == '0) ? ENTRY_ZERO : tbl_clr[ra];
            rd_tag[p*TAG_W +: TAG_W] = e.tag;
            rd_pending[p]            = e.pending;
        end
    end

    // The ROB hands out unique tags, so two pending entries sharing one
    // means an upstream bug.
    logic dup_tag;
    always_comb begin
        dup_tag = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            for (int j = i + 1; j < NUM_REGS; j++) begin
                if (tbl_q[i].pending && tbl_q[j].pending &&
                    tbl_q[i].tag == tbl_q[j].tag) begin
                    dup_tag = 1'b1;
                end
            end
        end
    end

    a_no_dup_tag: assert property (
        @(posedge clk) disable iff (rst) !dup_tag
    );

    a_cnt_range: assert property (
        @(posedge clk) disable iff (rst) pending_cnt <= CNT_W'(NUM_REGS - 1)
    );

endmodule

// File: tb/tb_rst_mp_ckpt.sv
// Directed bench for rst_mp_ckpt: rename, CDB bypass, checkpoints,
// x0 handling, flush and asynchronous reset.
module tb_rst_mp_ckpt;

    localparam int NUM_REGS = 32;
    localparam int TAG_W    = 6;
    localparam int NUM_DISP = 2;
    localparam int NUM_CDB  = 2;
    localparam int NUM_RD   = 4;
    localparam int NUM_CKPT = 4;
    localparam int AW       = 5;
    localparam int CW       = 2;
    localparam int CNT_W    = 6;

    logic                      clk;
    logic                      rst;
    logic                      flush;
    logic [NUM_DISP-1:0]       disp_valid;
    logic [NUM_DISP*AW-1:0]    disp_addr;
    logic [NUM_DISP*TAG_W-1:0] disp_tag;
    logic [NUM_RD*AW-1:0]      rd_addr;
    logic [NUM_RD*TAG_W-1:0]   rd_tag;
    logic [NUM_RD-1:0]         rd_pending;
    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic                      ckpt_take;
    logic [CW-1:0]             ckpt_id;
    logic                      ckpt_restore;
    logic [CW-1:0]             restore_id;
    logic [CNT_W-1:0]          pending_cnt;

    int n_vec;
    int n_err;

    rst_mp_ckpt #(
        .NUM_REGS (NUM_REGS),
        .TAG_W    (TAG_W),
        .NUM_DISP (NUM_DISP),
        .NUM_CDB  (NUM_CDB),
        .NUM_RD   (NUM_RD),
        .NUM_CKPT (NUM_CKPT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .disp_valid   (disp_valid),
        .disp_addr    (disp_addr),
        .disp_tag     (disp_tag),
        .rd_addr      (rd_addr),
        .rd_tag       (rd_tag),
        .rd_pending   (rd_pending),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .ckpt_take    (ckpt_take),
        .ckpt_id      (ckpt_id),
        .ckpt_restore (ckpt_restore),
        .restore_id   (restore_id),
        .pending_cnt  (pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        flush        = 1'b0;
        disp_valid   = '0;
        disp_addr    = '0;
        disp_tag     = '0;
        rd_addr      = '0;
        cdb_valid    = '0;
        cdb_tag      = '0;
        ckpt_take    = 1'b0;
        ckpt_id      = '0;
        ckpt_restore = 1'b0;
        restore_id   = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input int lane, input int addr, input int tag);
        disp_valid[lane]             = 1'b1;
        disp_addr[lane*AW +: AW]     = AW'(addr);
        disp_tag[lane*TAG_W +: TAG_W] = TAG_W'(tag);
    endtask

    task automatic set_cdb(input int bus, input int tag);
        cdb_valid[bus]               = 1'b1;
        cdb_tag[bus*TAG_W +: TAG_W]  = TAG_W'(tag);
    endtask

    // Drive one read port and sample it after settling.
    task automatic peek(input int port, input int r,
                        output logic p, output logic [TAG_W-1:0] t);
        rd_addr[port*AW +: AW] = AW'(r);
        #1;
        p = rd_pending[port];
        t = rd_tag[port*TAG_W +: TAG_W];
    endtask

    task automatic test_reset();
        logic             p;
        logic [TAG_W-1:0] t;
        idle();
        rst = 1'b1;
        set_disp(0, 3, 9);
        set_cdb(0, 9);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        n_vec++;
        if (pending_cnt !== 6'd0) begin
            $display("FAIL reset_cnt got %0d want 0", pending_cnt);
            n_err++;
        end
        for (int r = 1; r < NUM_REGS; r++) begin
            for (int q = 0; q < NUM_RD; q++) rd_addr[q*AW +: AW] = AW'(r);
            #1;
            n_vec++;
            if (rd_pending !== 4'b0000 || rd_tag !== '0) begin
                $display("FAIL reset_read x%0d got pend=%b tag=%h want 0/0",
                         r, rd_pending, rd_tag);
                n_err++;
            end
        end
        peek(0, 0, p, t);
        n_vec++;
        if (p !== 1'b0 || t !== 6'd0) begin
            $display("FAIL reset_x0 got %b/%0d want 0/0", p, t);
            n_err++;
        end
        step();
    endtask

    task automatic test_same_addr();
        logic             p;
        logic [TAG_W-1:0] t;
        idle();
        set_disp(0, 5, 3);
        set_disp(1, 5, 7);
        step();
        idle();
        peek(1, 5, p, t);
        n_vec++;
        if (p !== 1'b1 || t !== 6'd7) begin
            $display("FAIL lane_win got %b/%0d want 1/7", p, t);
            n_err++;
        end
        n_vec++;
        if (pending_cnt !== 6'd1) begin
            $display("FAIL lane_win_cnt got %0d want 1", pending_cnt);
            n_err++;
        end
        set_cdb(0, 3);
        peek(0, 5, p, t);
        n_vec++;
        if (p !== 1'b1 || t !== 6'd7) begin
            $display("FAIL cdb_stale_bypass got %b/%0d want 1/7", p, t);
            n_err++;
        end
        step();
        idle();
        peek(0, 5, p, t);
        n_vec++;
        if (p !== 1'b1 || t !== 6'd7) begin
            $display("FAIL cdb_stale got %b/%0d want 1/7", p, t);
            n_err++;
        end
        set_cdb(1, 7);
        peek(2, 5, p, t);
        n_vec++;
        if (p !== 1'b0 || t !== 6'd0) begin
            $display("FAIL cdb7_bypass got %b/%0d want 0/0", p, t);
            n_err++;
        end
        step();
        idle();
        peek(0, 5, p, t);
        n_vec++;
        if (p !== 1'b0 || t !== 6'd0 || pending_cnt !== 6'd0) begin
            $display("FAIL cdb7_clear got %b/%0d cnt=%0d want 0/0 cnt=0",
                     p, t, pending_cnt);
            n_err++;
        end
    endtask

    task automatic test_cdb_vs_disp();
        logic             p;
        logic [TAG_W-1:0] t;
        idle();
        set_disp(0, 6, 9);
        step();
        idle();
        set_cdb(0, 9);
        set_disp(0, 6, 12);
        peek(3, 6, p, t);
        n_vec++;
        if (p !== 1'b0 || t !== 6'd0) begin
            $display("FAIL x6_bypass got %b/%0d want 0/0", p, t);
            n_err++;
        end
        step();
        idle();
        peek(0, 6, p, t);
        n_vec++;
        if (p !== 1'b1 || t !== 6'd12 || pending_cnt !== 6'd1) begin
            $display("FAIL disp_over_cdb got %b/%0d cnt=%0d want 1/12 cnt=1",
                     p, t, pending_cnt);
            n_err++;
        end
        set_cdb(1, 12);
        step();
        idle();
    endtask

    task automatic test_ckpt();
        logic             p;
        logic [TAG_W-1:0] t;
        idle();
        set_disp(0, 2, 4);
        step();
        idle();
        ckpt_take = 1'b1;
        ckpt_id   = 2'd1;
        step();
        idle();
        set_disp(1, 2, 8);
        step();
        idle();
        set_cdb(0, 4);
        step();
        idle();
        ckpt_restore = 1'b1;
        restore_id   = 2'd1;
        step();
        idle();
        peek(0, 2, p, t);
        n_vec++;
        if (p !== 1'b0 || t !== 6'd0 || pending_cnt !== 6'd0) begin
            $display("FAIL restore_no_resurrect got %b/%0d cnt=%0d want 0/0 cnt=0",
                     p, t, pending_cnt);
            n_err++;
        end
        // Same-slot take and restore: restore wins, slot kept.
        set_disp(0, 3, 10);
        ckpt_take = 1'b1;
        ckpt_id   = 2'd2;
        step();
        idle();
        set_disp(0, 4, 11);
        ckpt_take    = 1'b1;
        ckpt_id      = 2'd2;
        ckpt_restore = 1'b1;
        restore_id   = 2'd2;
        step();
        idle();
        peek(0, 3, p, t);
        n_vec++;
        if (p !== 1'b1 || t !== 6'd10) begin
            $display("FAIL restore_x3 got %b/%0d want 1/10", p, t);
            n_err++;
        end
        peek(1, 4, p, t);
        n_vec++;
        if (p !== 1'b0 || pending_cnt !== 6'd1) begin
            $display("FAIL restore_drops_disp got x4=%b cnt=%0d want 0 cnt=1",
                     p, pending_cnt);
            n_err++;
        end
        set_disp(1, 7, 13);
        step();
        idle();
        n_vec++;
        if (pending_cnt !== 6'd2) begin
            $display("FAIL cnt_two got %0d want 2", pending_cnt);
            n_err++;
        end
        ckpt_restore = 1'b1;
        restore_id   = 2'd2;
        step();
        idle();
        peek(0, 7, p, t);
        n_vec++;
        if (p !== 1'b0 || pending_cnt !== 6'd1) begin
            $display("FAIL slot_unchanged got x7=%b cnt=%0d want 0 cnt=1",
                     p, pending_cnt);
            n_err++;
        end
        peek(1, 4, p, t);
        n_vec++;
        if (p !== 1'b0) begin
            $display("FAIL slot_no_take got x4=%b want 0", p);
            n_err++;
        end
        set_cdb(0, 10);
        step();
        idle();
        n_vec++;
        if (pending_cnt !== 6'd0) begin
            $display("FAIL ckpt_drain got %0d want 0", pending_cnt);
            n_err++;
        end
    endtask

    task automatic test_x0_flush();
        logic             p;
        logic [TAG_W-1:0] t;
        idle();
        set_disp(0, 0, 5);
        step();
        idle();
        peek(0, 0, p, t);
        n_vec++;
        if (p !== 1'b0 || t !== 6'd0 || pending_cnt !== 6'd0) begin
            $display("FAIL x0_ignored got %b/%0d cnt=%0d want 0/0 cnt=0",
                     p, t, pending_cnt);
            n_err++;
        end
        for (int i = 0; i < 5; i++) begin
            set_disp(0, 10 + 2*i, 20 + 2*i);
            set_disp(1, 11 + 2*i, 21 + 2*i);
            if (i == 4) begin
                ckpt_take = 1'b1;
                ckpt_id   = 2'd3;
            end
            step();
            idle();
        end
        n_vec++;
        if (pending_cnt !== 6'd10) begin
            $display("FAIL cnt_ten got %0d want 10", pending_cnt);
            n_err++;
        end
        set_cdb(0, 20);
        set_cdb(1, 21);
        step();
        idle();
        peek(0, 12, p, t);
        n_vec++;
        if (p !== 1'b1 || t !== 6'd22 || pending_cnt !== 6'd8) begin
            $display("FAIL dual_cdb got %b/%0d cnt=%0d want 1/22 cnt=8",
                     p, t, pending_cnt);
            n_err++;
        end
        flush = 1'b1;
        step();
        idle();
        peek(0, 12, p, t);
        n_vec++;
        if (p !== 1'b0 || pending_cnt !== 6'd0) begin
            $display("FAIL flush got %b cnt=%0d want 0 cnt=0", p, pending_cnt);
            n_err++;
        end
        ckpt_restore = 1'b1;
        restore_id   = 2'd3;
        step();
        idle();
        n_vec++;
        if (pending_cnt !== 6'd0) begin
            $display("FAIL flush_ckpt got cnt=%0d want 0", pending_cnt);
            n_err++;
        end
    endtask

    task automatic test_async_rst();
        logic             p;
        logic [TAG_W-1:0] t;
        idle();
        set_disp(0, 8, 30);
        step();
        idle();
        ckpt_take = 1'b1;
        ckpt_id   = 2'd0;
        step();
        idle();
        n_vec++;
        if (pending_cnt !== 6'd1) begin
            $display("FAIL pre_rst_cnt got %0d want 1", pending_cnt);
            n_err++;
        end
        ckpt_restore = 1'b1;
        restore_id   = 2'd0;
        set_disp(0, 9, 31);
        #2;
        rst = 1'b1;
        #1;
        peek(0, 8, p, t);
        n_vec++;
        if (p !== 1'b0 || pending_cnt !== 6'd0) begin
            $display("FAIL async_rst got %b cnt=%0d want 0 cnt=0", p, pending_cnt);
            n_err++;
        end
        step();
        rst = 1'b0;
        idle();
        for (int k = 0; k < NUM_CKPT; k++) begin
            ckpt_restore = 1'b1;
            restore_id   = CW'(k);
            step();
            idle();
            peek(0, 8, p, t);
            n_vec++;
            if (p !== 1'b0 || pending_cnt !== 6'd0) begin
                $display("FAIL rst_ckpt%0d got %b cnt=%0d want 0 cnt=0",
                         k, p, pending_cnt);
                n_err++;
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        idle();
        test_reset();
        test_same_addr();
        test_cdb_vs_disp();
        test_ckpt();
        test_x0_flush();
        test_async_rst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
